// File: rtl/merlin_ibus_arbiter.sv
// rtl/merlin_ibus_arbiter.sv - two-master (fetch/LSU) to one-slave bus arbiter with in-order response routing
//
// Shares one memory bus port between the instruction prefetch master (I) and the
// load/store master (D). D wins contested cycles. After C_STARVE_LIMIT contested
// D grants in a row, the next contested cycle goes to I. A small owner FIFO
// records who issued each outstanding bus request so that the in-order bus
// responses can be steered back to the right master.
//
// Parameters
//   C_OUTSTANDING_X : log2 of owner FIFO depth (max outstanding requests), 1..4
//   C_STARVE_LIMIT  : contested D grants before I is forced through, 1..15
//
// Ports
//   clk_i, reset_i     : clock (rising edge), asynchronous active-low reset
//   clk_en_i           : clock enable, gates every handshake and state update
//   ireq* / irsp*      : instruction master request / response channels
//   dreq* / drsp*      : data master request / response channels
//   breq* / brsp*      : shared bus request / response channels
//
// The request and response paths are both purely combinational. Only the
// owner FIFO and the starvation counter are registered.

module merlin_ibus_arbiter #(
    parameter int C_OUTSTANDING_X = 2,
    parameter int C_STARVE_LIMIT  = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,

    // instruction master
    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,
    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,

    // data master
    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic        dreqwr_i,
    input  logic [1:0]  dreqsize_i,
    input  logic [31:0] dreqdata_i,
    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic [31:0] drspdata_o,

    // shared bus
    input  logic        breqready_i,
    output logic        breqvalid_o,
    output logic [1:0]  breqhpl_o,
    output logic [31:0] breqaddr_o,
    output logic        breqwr_o,
    output logic [1:0]  breqsize_o,
    output logic [31:0] breqdata_o,
    output logic        brspready_o,
    input  logic        brspvalid_i,
    input  logic        brsprerr_i,
    input  logic [31:0] brspdata_i
);

    localparam int                       DEPTH      = 1 << C_OUTSTANDING_X;
    localparam logic [C_OUTSTANDING_X:0] LVL_FULL   = {1'b1, {C_OUTSTANDING_X{1'b0}}};
    localparam logic [3:0]               STARVE_LIM = 4'(C_STARVE_LIMIT);

    // owner FIFO: one bit per outstanding request, 0 = I, 1 = D
    logic [DEPTH-1:0]           owner_q;
    logic [C_OUTSTANDING_X-1:0] wp;
    logic [C_OUTSTANDING_X-1:0] rp;
    logic [C_OUTSTANDING_X:0]   lvl;
    logic [3:0]                 starve_q;

    logic can_issue;
    logic grant_i;
    logic grant_d;
    logic push;
    logic pop;
    logic lvl_nz;
    logic head_d;
    logic sel_i;
    logic sel_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // A full FIFO blocks issue. A slot freed by a response in this cycle
    // only becomes usable next cycle, which keeps ready off the response path.
    assign can_issue = (lvl != LVL_FULL);

    // The grant depends only on the valids and the registered starve count.
    // A master holding its request therefore keeps its grant until the
    // handshake. The count changes only on a handshake.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (ireqvalid_i && dreqvalid_i) begin
            if (starve_q == STARVE_LIM) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = ireqvalid_i;
            grant_d = dreqvalid_i;
        end
    end

    assign breqvalid_o = can_issue & (ireqvalid_i | dreqvalid_i);
    assign ireqready_o = grant_i & can_issue & breqready_i;
    assign dreqready_o = grant_d & can_issue & breqready_i;

    // ------------------------------------------------------------------
    // Request mux
    // ------------------------------------------------------------------
    // Fetches are always word reads on a word-aligned address.
    always_comb begin
        breqhpl_o  = 2'b00;
        breqaddr_o = 32'h0;
        breqwr_o   = 1'b0;
        breqsize_o = 2'b00;
        breqdata_o = 32'h0;
        if (grant_d) begin
            breqhpl_o  = dreqhpl_i;
            breqaddr_o = dreqaddr_i;
            breqwr_o   = dreqwr_i;
            breqsize_o = dreqsize_i;
            breqdata_o = dreqdata_i;
        end else if (grant_i) begin
            breqhpl_o  = ireqhpl_i;
            breqaddr_o = {ireqaddr_i[31:2], 2'b00};
            breqwr_o   = 1'b0;
            breqsize_o = 2'b10;
            breqdata_o = 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // With nothing outstanding, any bus response is a slave protocol error.
    // It is neither accepted nor forwarded.
    assign lvl_nz = (lvl != '0);
    assign head_d = owner_q[rp];
    assign sel_i  = lvl_nz & ~head_d;
    assign sel_d  = lvl_nz &  head_d;

    assign brspready_o = (sel_i & irspready_i) | (sel_d & drspready_i);

    assign irspvalid_o = brspvalid_i & sel_i;
    assign irsprerr_o  = brsprerr_i  & sel_i;
    assign irspdata_o  = sel_i ? brspdata_i : 32'h0;

    assign drspvalid_o = brspvalid_i & sel_d;
    assign drsprerr_o  = brsprerr_i  & sel_d;
    assign drspdata_o  = sel_d ? brspdata_i : 32'h0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    assign push = breqvalid_o & breqready_i & clk_en_i;
    assign pop  = brspvalid_i & brspready_o & clk_en_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            owner_q  <= '0;
            wp       <= '0;
            rp       <= '0;
            lvl      <= '0;
            starve_q <= 4'd0;
        end else begin
            if (push) begin
                owner_q[wp] <= grant_d;
                wp          <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase

            // Only D grants won against a waiting I count toward starvation.
            if (push && grant_i) begin
                starve_q <= 4'd0;
            end else if (push && grant_d && ireqvalid_i && (starve_q < STARVE_LIM)) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_merlin_ibus_arbiter.sv
// tb/tb_merlin_ibus_arbiter.sv - self-checking bench for merlin_ibus_arbiter

module tb_merlin_ibus_arbiter;

    localparam int X     = 2;
    localparam int DEPTH = 1 << X;
    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        ireqready_o;
    logic        ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;
    logic        dreqready_o;
    logic        dreqvalid_i;
    logic [1:0]  dreqhpl_i;
    logic [31:0] dreqaddr_i;
    logic        dreqwr_i;
    logic [1:0]  dreqsize_i;
    logic [31:0] dreqdata_i;
    logic        drspready_i;
    logic        drspvalid_o;
    logic        drsprerr_o;
    logic [31:0] drspdata_o;
    logic        breqready_i;
    logic        breqvalid_o;
    logic [1:0]  breqhpl_o;
    logic [31:0] breqaddr_o;
    logic        breqwr_o;
    logic [1:0]  breqsize_o;
    logic [31:0] breqdata_o;
    logic        brspready_o;
    logic        brspvalid_i;
    logic        brsprerr_i;
    logic [31:0] brspdata_i;

    merlin_ibus_arbiter #(.C_OUTSTANDING_X(X), .C_STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
        .ireqaddr_i(ireqaddr_i), .irspready_i(irspready_i), .irspvalid_o(irspvalid_o),
        .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
        .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqhpl_i(dreqhpl_i),
        .dreqaddr_i(dreqaddr_i), .dreqwr_i(dreqwr_i), .dreqsize_i(dreqsize_i),
        .dreqdata_i(dreqdata_i), .drspready_i(drspready_i), .drspvalid_o(drspvalid_o),
        .drsprerr_o(drsprerr_o), .drspdata_o(drspdata_o),
        .breqready_i(breqready_i), .breqvalid_o(breqvalid_o), .breqhpl_o(breqhpl_o),
        .breqaddr_o(breqaddr_o), .breqwr_o(breqwr_o), .breqsize_o(breqsize_o),
        .breqdata_o(breqdata_o), .brspready_o(brspready_o), .brspvalid_i(brspvalid_i),
        .brsprerr_i(brsprerr_i), .brspdata_i(brspdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit        mq[$];          // outstanding owners, front = oldest, 1 = D
    int        m_starve;
    bit        m_gi, m_gd;
    bit        e_bvalid, e_iready, e_dready, e_brspready;
    bit        e_irspvalid, e_drspvalid, e_irsprerr, e_drsprerr;
    bit        e_bwr;
    bit [1:0]  e_bhpl, e_bsize;
    bit [31:0] e_baddr, e_bdata, e_irspdata, e_drspdata;
    logic      g_i, g_d;       // DUT readys sampled in the last step

    task automatic model_expect();
        bit can, nz, hd;
        can  = (mq.size() < DEPTH);
        m_gi = 1'b0;
        m_gd = 1'b0;
        if (ireqvalid_i && dreqvalid_i) begin
            if (m_starve == LIMIT) m_gi = 1'b1; else m_gd = 1'b1;
        end else if (ireqvalid_i) begin
            m_gi = 1'b1;
        end else if (dreqvalid_i) begin
            m_gd = 1'b1;
        end
        e_bvalid = can && (ireqvalid_i || dreqvalid_i);
        e_iready = m_gi && can && breqready_i;
        e_dready = m_gd && can && breqready_i;
        e_bhpl = 0; e_baddr = 0; e_bwr = 0; e_bsize = 0; e_bdata = 0;
        if (m_gd) begin
            e_bhpl = dreqhpl_i; e_baddr = dreqaddr_i; e_bwr = dreqwr_i;
            e_bsize = dreqsize_i; e_bdata = dreqdata_i;
        end else if (m_gi) begin
            e_bhpl = ireqhpl_i; e_baddr = ireqaddr_i & 32'hFFFF_FFFC; e_bsize = 2'b10;
        end
        nz = (mq.size() != 0);
        hd = nz ? mq[0] : 1'b0;
        e_brspready = nz && (hd ? drspready_i : irspready_i);
        e_irspvalid = brspvalid_i && nz && !hd;
        e_drspvalid = brspvalid_i && nz && hd;
        e_irsprerr  = brsprerr_i && nz && !hd;
        e_drsprerr  = brsprerr_i && nz && hd;
        e_irspdata  = (nz && !hd) ? brspdata_i : 32'h0;
        e_drspdata  = (nz && hd)  ? brspdata_i : 32'h0;
    endtask

    task automatic model_update();
        bit push, pop;
        if (!clk_en_i) return;
        push = e_bvalid && breqready_i;
        pop  = brspvalid_i && e_brspready;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(m_gd);
        if (push && m_gi) m_starve = 0;
        else if (push && m_gd && ireqvalid_i && m_starve < LIMIT) m_starve++;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".breqvalid"}, breqvalid_o, e_bvalid);
        chk({tag, ".ireqready"}, ireqready_o, e_iready);
        chk({tag, ".dreqready"}, dreqready_o, e_dready);
        chk({tag, ".breqhpl"},   breqhpl_o,   e_bhpl);
        chk({tag, ".breqaddr"},  breqaddr_o,  e_baddr);
        chk({tag, ".breqwr"},    breqwr_o,    e_bwr);
        chk({tag, ".breqsize"},  breqsize_o,  e_bsize);
        chk({tag, ".breqdata"},  breqdata_o,  e_bdata);
        chk({tag, ".brspready"}, brspready_o, e_brspready);
        chk({tag, ".irspvalid"}, irspvalid_o, e_irspvalid);
        chk({tag, ".drspvalid"}, drspvalid_o, e_drspvalid);
        chk({tag, ".irsprerr"},  irsprerr_o,  e_irsprerr);
        chk({tag, ".drsprerr"},  drsprerr_o,  e_drsprerr);
        chk({tag, ".irspdata"},  irspdata_o,  e_irspdata);
        chk({tag, ".drspdata"},  drspdata_o,  e_drspdata);
    endtask

    // Called just after a rising edge with inputs already set; returns just
    // after the next rising edge.
    task automatic step(input string tag);
        model_expect();
        @(negedge clk_i);
        compare_all(tag);
        g_i = ireqready_o;
        g_d = dreqready_o;
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        clk_en_i = 1'b1;
        ireqvalid_i = 0; ireqhpl_i = 0; ireqaddr_i = 0; irspready_i = 0;
        dreqvalid_i = 0; dreqhpl_i = 0; dreqaddr_i = 0; dreqwr_i = 0;
        dreqsize_i = 0; dreqdata_i = 0; drspready_i = 0;
        breqready_i = 0; brspvalid_i = 0; brsprerr_i = 0; brspdata_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1'b0;
        mq.delete();
        m_starve = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic iv; logic [31:0] ia; logic [1:0] ih;
        logic dv; logic [31:0] da; logic dw; logic [1:0] ds; logic [31:0] dd; logic [1:0] dh;
        logic brdy;
        logic ev; logic [31:0] ea; logic [1:0] es; logic ew; logic [31:0] ed; logic [1:0] eh;
        logic eir; logic edr;
    } vec_t;

    vec_t vecs[6];
    bit   exp_grant_d[10];
    int   n_acc;

    initial begin
        vecs[0] = '{0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,  0, 1, 0, 32'h0,    0, 0, 32'h0,  0, 0, 0};
        vecs[1] = '{1, 32'h1003, 3, 0, 32'h0,    0, 0, 32'h0,  0, 1, 1, 32'h1000, 2, 0, 32'h0,  3, 1, 0};
        vecs[2] = '{0, 32'h0,    0, 1, 32'h2001, 1, 0, 32'h55, 1, 1, 1, 32'h2001, 0, 1, 32'h55, 1, 0, 1};
        vecs[3] = '{1, 32'h1003, 3, 1, 32'h2002, 0, 1, 32'h77, 2, 1, 1, 32'h2002, 1, 0, 32'h77, 2, 0, 1};
        vecs[4] = '{1, 32'h1003, 3, 1, 32'h2002, 0, 1, 32'h77, 2, 0, 1, 32'h2002, 1, 0, 32'h77, 2, 0, 0};
        vecs[5] = '{1, 32'h1003, 3, 0, 32'h0,    0, 0, 32'h0,  0, 0, 1, 32'h1000, 2, 0, 32'h0,  3, 0, 0};
        exp_grant_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // ---- reset state ----
        do_reset();
        brspvalid_i = 1; brspdata_i = 32'h1234_5678; irspready_i = 1; drspready_i = 1;
        #2;
        chk("rst.brspready", brspready_o, 1'b0);
        chk("rst.irspvalid", irspvalid_o, 1'b0);
        chk("rst.drspvalid", drspvalid_o, 1'b0);
        chk("rst.breqvalid", breqvalid_o, 1'b0);

        // ---- table: combinational request path, clock disabled ----
        do_reset();
        clk_en_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ireqvalid_i = vecs[k].iv; ireqaddr_i = vecs[k].ia; ireqhpl_i = vecs[k].ih;
            dreqvalid_i = vecs[k].dv; dreqaddr_i = vecs[k].da; dreqwr_i = vecs[k].dw;
            dreqsize_i = vecs[k].ds; dreqdata_i = vecs[k].dd; dreqhpl_i = vecs[k].dh;
            breqready_i = vecs[k].brdy;
            @(negedge clk_i);
            chk($sformatf("vec%0d.breqvalid", k), breqvalid_o, vecs[k].ev);
            chk($sformatf("vec%0d.breqaddr", k),  breqaddr_o,  vecs[k].ea);
            chk($sformatf("vec%0d.breqsize", k),  breqsize_o,  vecs[k].es);
            chk($sformatf("vec%0d.breqwr", k),    breqwr_o,    vecs[k].ew);
            chk($sformatf("vec%0d.breqdata", k),  breqdata_o,  vecs[k].ed);
            chk($sformatf("vec%0d.breqhpl", k),   breqhpl_o,   vecs[k].eh);
            chk($sformatf("vec%0d.ireqready", k), ireqready_o, vecs[k].eir);
            chk($sformatf("vec%0d.dreqready", k), dreqready_o, vecs[k].edr);
            @(posedge clk_i);
            #1;
        end

        // ---- 1: I only ----
        do_reset();
        ireqvalid_i = 1; ireqaddr_i = 32'h1006; breqready_i = 1;
        @(negedge clk_i);
        chk("t1.breqaddr", breqaddr_o, 32'h1004);
        chk("t1.breqsize", breqsize_o, 2'b10);
        chk("t1.breqwr",   breqwr_o,   1'b0);
        @(posedge clk_i); #1;
        step("t1.req");
        ireqvalid_i = 0;
        brspvalid_i = 1; brspdata_i = 32'hDEADBEEF; irspready_i = 1; drspready_i = 1;
        step("t1.rsp");
        // step saw the model's values; the plain constants below pin the test case
        brspvalid_i = 1;
        chk("t1.drspvalid_after", drspvalid_o, 1'b0);

        // ---- 2: contention grant order ----
        do_reset();
        ireqvalid_i = 1; ireqaddr_i = 32'h400; dreqvalid_i = 1; dreqaddr_i = 32'h800;
        dreqsize_i = 2'b10; breqready_i = 1; brspvalid_i = 1; brspdata_i = 32'h99;
        irspready_i = 1; drspready_i = 1;
        for (int k = 0; k < 10; k++) begin
            step($sformatf("t2.c%0d", k));
            chk($sformatf("t2.grant_d%0d", k), g_d, exp_grant_d[k]);
            chk($sformatf("t2.grant_i%0d", k), g_i, !exp_grant_d[k]);
        end

        // ---- 3: FIFO full ----
        do_reset();
        dreqvalid_i = 1; dreqaddr_i = 32'h3000; breqready_i = 1; drspready_i = 1;
        for (int k = 0; k < DEPTH; k++) begin
            step("t3.fill");
            chk($sformatf("t3.accept%0d", k), g_d, 1'b1);
        end
        @(negedge clk_i);
        chk("t3.full_breqvalid", breqvalid_o, 1'b0);
        chk("t3.full_dreqready", dreqready_o, 1'b0);
        @(posedge clk_i); #1;
        brspvalid_i = 1;
        step("t3.pop");
        chk("t3.no_bypass", g_d, 1'b0);
        brspvalid_i = 0;
        step("t3.resume");
        chk("t3.resumed", g_d, 1'b1);

        // ---- 4: interleaved routing ----
        do_reset();
        breqready_i = 1;
        dreqvalid_i = 1; step("t4.d0"); dreqvalid_i = 0;
        ireqvalid_i = 1; step("t4.i0"); ireqvalid_i = 0;
        dreqvalid_i = 1; step("t4.d1"); dreqvalid_i = 0;
        brspvalid_i = 1; irspready_i = 1; drspready_i = 1; brspdata_i = 32'hA;
        @(negedge clk_i);
        chk("t4.A_dvalid", drspvalid_o, 1'b1);
        chk("t4.A_ddata",  drspdata_o,  32'hA);
        chk("t4.A_ivalid", irspvalid_o, 1'b0);
        @(posedge clk_i); #1;
        model_expect(); model_update();
        brspdata_i = 32'hB; irspready_i = 0;
        for (int k = 0; k < 2; k++) begin
            step("t4.Bstall");
            @(negedge clk_i);
            chk($sformatf("t4.Bstall_ready%0d", k), brspready_o, 1'b0);
            chk($sformatf("t4.Bstall_ivalid%0d", k), irspvalid_o, 1'b1);
            @(posedge clk_i); #1;
        end
        irspready_i = 1;
        @(negedge clk_i);
        chk("t4.B_idata",  irspdata_o,  32'hB);
        chk("t4.B_dvalid", drspvalid_o, 1'b0);
        chk("t4.B_ready",  brspready_o, 1'b1);
        @(posedge clk_i); #1;
        model_expect(); model_update();
        brspdata_i = 32'hC;
        @(negedge clk_i);
        chk("t4.C_dvalid", drspvalid_o, 1'b1);
        chk("t4.C_ddata",  drspdata_o,  32'hC);
        @(posedge clk_i); #1;
        model_expect(); model_update();
        brspvalid_i = 0;

        // ---- 5: simultaneous push/pop, spurious response ----
        do_reset();
        breqready_i = 1; dreqvalid_i = 1; drspready_i = 1;
        step("t5.p0"); step("t5.p1");
        brspvalid_i = 1;
        step("t5.pushpop");
        brspvalid_i = 0;
        n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            step("t5.fill");
            if (g_d) n_acc++;
        end
        chk("t5.lvl_two_slots_left", n_acc, 2);
        do_reset();
        brspvalid_i = 1; irspready_i = 1; drspready_i = 1;
        step("t5.spurious");
        @(negedge clk_i);
        chk("t5.spur_ivalid", irspvalid_o, 1'b0);
        chk("t5.spur_dvalid", drspvalid_o, 1'b0);
        @(posedge clk_i); #1;

        // ---- 6: async reset mid-burst, clock enable ----
        do_reset();
        breqready_i = 1; dreqvalid_i = 1;
        for (int k = 0; k < 3; k++) step("t6.fill");
        dreqvalid_i = 0; brspvalid_i = 1; drspready_i = 1;
        #2;
        chk("t6.pre_dvalid", drspvalid_o, 1'b1);
        reset_i = 1'b0;
        #1;
        chk("t6.rst_dvalid", drspvalid_o, 1'b0);
        chk("t6.rst_ivalid", irspvalid_o, 1'b0);
        chk("t6.rst_ready",  brspready_o, 1'b0);
        mq.delete(); m_starve = 0;
        @(negedge clk_i); reset_i = 1'b1;
        @(posedge clk_i); #1;
        step("t6.after_rst");
        @(negedge clk_i);
        chk("t6.after_rst_ready", brspready_o, 1'b0);
        @(posedge clk_i); #1;
        brspvalid_i = 0;
        do_reset();
        clk_en_i = 0; ireqvalid_i = 1; dreqvalid_i = 1; breqready_i = 1;
        for (int k = 0; k < 6; k++) step("t6.clk_en_off");
        clk_en_i = 1; brspvalid_i = 1; irspready_i = 1; drspready_i = 1;
        for (int k = 0; k < 5; k++) begin
            step("t6.order");
            chk($sformatf("t6.grant_d%0d", k), g_d, exp_grant_d[k]);
        end

        // ---- randomized against the model ----
        do_reset();
        for (int n = 0; n < 600; n++) begin
            clk_en_i    = ($urandom_range(0, 7) != 0);
            ireqvalid_i = $urandom_range(0, 1);
            ireqaddr_i  = $urandom;
            ireqhpl_i   = 2'($urandom);
            dreqvalid_i = $urandom_range(0, 1);
            dreqaddr_i  = $urandom;
            dreqhpl_i   = 2'($urandom);
            dreqwr_i    = $urandom_range(0, 1);
            dreqsize_i  = 2'($urandom_range(0, 2));
            dreqdata_i  = $urandom;
            breqready_i = ($urandom_range(0, 3) != 0);
            brspvalid_i = $urandom_range(0, 1);
            brsprerr_i  = ($urandom_range(0, 7) == 0);
            brspdata_i  = $urandom;
            irspready_i = ($urandom_range(0, 3) != 0);
            drspready_i = ($urandom_range(0, 3) != 0);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
